// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the L2 request arbiter.
package l2_arb_pkg;

  localparam int unsigned L2_ARB_NUM_REQUESTERS = 4;
  localparam int unsigned L2_ARB_ADDR_W         = 30;
  localparam int unsigned L2_ARB_DATA_W         = 32;
  localparam int unsigned L2_ARB_BURST_W        = 5;
  localparam int unsigned L2_ARB_ID_W           = $clog2(L2_ARB_NUM_REQUESTERS);

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } l2_arb_state_t;

  typedef struct packed {
    logic [L2_ARB_ID_W-1:0]    id;
    logic                      rnw;
    logic [L2_ARB_BURST_W-1:0] burst_len;
    logic [L2_ARB_ADDR_W-1:0]  addr;
  } l2_arb_request_t;

endpackage

// File: rtl/l2_rr_select.sv
// Rotate-priority encoder: first set bit of valid, searching upward from ptr with wrap.
module l2_rr_select #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  int unsigned idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!any_valid && valid[idx]) begin
        winner    = IDX_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares the L2 request and write-data FIFOs between requesters; writes hold ownership for the burst.
// Define L2_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module l2_request_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = L2_ARB_NUM_REQUESTERS,
  parameter int unsigned ADDR_W         = L2_ARB_ADDR_W,
  parameter int unsigned DATA_W         = L2_ARB_DATA_W,
  parameter int unsigned BURST_W        = L2_ARB_BURST_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQUESTERS-1:0]         req_valid,
  input  logic [NUM_REQUESTERS*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQUESTERS-1:0]         req_rnw,
  input  logic [NUM_REQUESTERS*BURST_W-1:0] req_burst_len,
  output logic [NUM_REQUESTERS-1:0]         req_ack,
  input  logic [NUM_REQUESTERS-1:0]         wr_valid,
  input  logic [NUM_REQUESTERS*DATA_W-1:0]  wr_data,
  output logic [NUM_REQUESTERS-1:0]         wr_ack,
  output logic                              rq_push,
  output l2_arb_request_t                   rq_data,
  input  logic                              rq_full,
  output logic                              wd_push,
  output logic [DATA_W-1:0]                 wd_data,
  input  logic                              wd_full,
  output logic                              busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQUESTERS);

  l2_arb_state_t      state;
  logic [IDX_W-1:0]   owner;
  logic [BURST_W-1:0] words_left;
  logic [IDX_W-1:0]   sel_ptr;
  logic [IDX_W-1:0]   winner;
  logic               any_valid;
  logic               grant;
  logic               beat;

`ifdef L2_ARB_FIXED_PRIORITY_EN
  assign sel_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr;
  assign sel_ptr = rr_ptr;
`endif

  l2_rr_select #(
    .N     (NUM_REQUESTERS),
    .IDX_W (IDX_W)
  ) u_select (
    .valid     (req_valid),
    .ptr       (sel_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Gating on rst keeps every output low while reset is held, even mid-cycle.
  assign grant = !rst && (state == IDLE) && any_valid && !rq_full;
  assign beat  = (state == WDATA) && wr_valid[owner] && !wd_full;

  always_comb begin
    req_ack           = '0;
    wr_ack            = '0;
    rq_push           = grant;
    wd_push           = beat;
    busy              = (state == WDATA);
    rq_data.id        = L2_ARB_ID_W'(winner);
    rq_data.rnw       = req_rnw[winner];
    rq_data.burst_len = L2_ARB_BURST_W'(req_burst_len[winner*BURST_W +: BURST_W]);
    rq_data.addr      = L2_ARB_ADDR_W'(req_addr[winner*ADDR_W +: ADDR_W]);
    wd_data           = wr_data[owner*DATA_W +: DATA_W];
    if (grant) req_ack[winner] = 1'b1;
    if (beat)  wr_ack[owner]   = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      words_left <= '0;
`ifndef L2_ARB_FIXED_PRIORITY_EN
      rr_ptr     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
`ifndef L2_ARB_FIXED_PRIORITY_EN
            rr_ptr <= (32'(winner) == NUM_REQUESTERS - 1) ? '0 : winner + 1'b1;
`endif
            if (!req_rnw[winner]) begin
              state      <= WDATA;
              owner      <= winner;
              words_left <= req_burst_len[winner*BURST_W +: BURST_W];
            end
          end
        end
        WDATA: begin
          // The beat consumed with words_left == 0 is the last of the burst.
          if (beat) begin
            if (words_left == '0) state <= IDLE;
            else                  words_left <= words_left - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Bench for l2_request_arbiter: cycle model checked every cycle plus directed literal checks.
module tb_l2_request_arbiter;
  import l2_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 5;

  logic                clk;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N*AW-1:0]     req_addr;
  logic [N-1:0]        req_rnw;
  logic [N*BW-1:0]     req_burst_len;
  logic [N-1:0]        req_ack;
  logic [N-1:0]        wr_valid;
  logic [N*DW-1:0]     wr_data;
  logic [N-1:0]        wr_ack;
  logic                rq_push;
  l2_arb_request_t     rq_data;
  logic                rq_full;
  logic                wd_push;
  logic [DW-1:0]       wd_data;
  logic                wd_full;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;

  l2_request_arbiter #(
    .NUM_REQUESTERS (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .BURST_W        (BW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_rnw       (req_rnw),
    .req_burst_len (req_burst_len),
    .req_ack       (req_ack),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .rq_push       (rq_push),
    .rq_data       (rq_data),
    .rq_full       (rq_full),
    .wd_push       (wd_push),
    .wd_data       (wd_data),
    .wd_full       (wd_full),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the write path, how many words remain, where the search starts.
  bit m_busy;
  int m_owner;
  int m_left;
  int m_rr;

  always @(negedge clk) begin
    logic [N-1:0]    e_ack;
    logic [N-1:0]    e_wack;
    logic            e_push;
    logic            e_wpush;
    l2_arb_request_t e_req;
    int              w;
    if (rst) begin
      chk("rst_req_ack", 64'(req_ack), 64'(0));
      chk("rst_rq_push", 64'(rq_push), 64'(0));
      chk("rst_wd_push", 64'(wd_push), 64'(0));
      chk("rst_wr_ack",  64'(wr_ack),  64'(0));
      chk("rst_busy",    64'(busy),    64'(0));
      m_busy = 0; m_owner = 0; m_left = 0; m_rr = 0;
    end else begin
      e_ack = '0; e_wack = '0; e_push = 1'b0; e_wpush = 1'b0; w = -1;
      e_req = '0;
      if (!m_busy) begin
        if (!rq_full)
          for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
        if (w >= 0) begin
          e_ack[w]        = 1'b1;
          e_push          = 1'b1;
          e_req.id        = L2_ARB_ID_W'(w);
          e_req.rnw       = req_rnw[w];
          e_req.burst_len = req_burst_len[w*BW +: BW];
          e_req.addr      = req_addr[w*AW +: AW];
        end
      end else begin
        e_wpush = wr_valid[m_owner] && !wd_full;
        if (e_wpush) e_wack[m_owner] = 1'b1;
      end
      chk("m_req_ack", 64'(req_ack), 64'(e_ack));
      chk("m_rq_push", 64'(rq_push), 64'(e_push));
      chk("m_wd_push", 64'(wd_push), 64'(e_wpush));
      chk("m_wr_ack",  64'(wr_ack),  64'(e_wack));
      chk("m_busy",    64'(busy),    64'(m_busy));
      if (e_push)  chk("m_rq_data", 64'(rq_data), 64'(e_req));
      if (e_wpush) chk("m_wd_data", 64'(wd_data), 64'(wr_data[m_owner*DW +: DW]));
      if (e_push) begin
`ifndef L2_ARB_FIXED_PRIORITY_EN
        m_rr = (w + 1) % N;
`endif
        if (!req_rnw[w]) begin
          m_busy  = 1;
          m_owner = w;
          m_left  = int'(req_burst_len[w*BW +: BW]) + 1;
        end
      end
      if (e_wpush) begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic rnw, input logic [AW-1:0] a, input logic [BW-1:0] bl);
    req_valid[p]             = 1'b1;
    req_rnw[p]               = rnw;
    req_addr[p*AW +: AW]     = a;
    req_burst_len[p*BW +: BW] = bl;
  endtask

  logic [N-1:0] order_rr [5];
  logic [N-1:0] order_fp [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_rnw = '0; req_burst_len = '0;
    wr_valid = '0; wr_data = '0; rq_full = 1'b0; wd_full = 1'b0;
    order_rr[0] = 4'b0001; order_rr[1] = 4'b0010; order_rr[2] = 4'b0100;
    order_rr[3] = 4'b1000; order_rr[4] = 4'b0001;
    for (int i = 0; i < 5; i++) order_fp[i] = 4'b0001;
    #2;
    chk("reset_busy",    64'(busy),    64'(0));
    chk("reset_req_ack", 64'(req_ack), 64'(0));
    cyc(); cyc();
    rst = 1'b0;

    // Single read from port 2.
    set_req(2, 1'b1, 30'h100, 5'd0);
    #1;
    chk("rd2_ack",  64'(req_ack),    64'(4'b0100));
    chk("rd2_push", 64'(rq_push),    64'(1));
    chk("rd2_id",   64'(rq_data.id), 64'(2));
    chk("rd2_addr", 64'(rq_data.addr), 64'(30'h100));
    cyc();
    req_valid = '0;
    set_req(0, 1'b1, 30'h200, 5'd0);
    set_req(3, 1'b1, 30'h300, 5'd0);
    #1;
`ifdef L2_ARB_FIXED_PRIORITY_EN
    chk("rr_after2", 64'(req_ack), 64'(4'b0001));
    cyc(); req_valid[0] = 1'b0; #1;
    chk("rr_next",   64'(req_ack), 64'(4'b1000));
    cyc(); req_valid = '0;
`else
    chk("rr_after2", 64'(req_ack), 64'(4'b1000));
    cyc(); req_valid[3] = 1'b0; #1;
    chk("rr_next",   64'(req_ack), 64'(4'b0001));
    cyc(); req_valid = '0;
    set_req(3, 1'b1, 30'h301, 5'd0);
    #1;
    cyc(); req_valid = '0;
`endif

    // All four ports hold reads: search pointer is back at 0 here.
    for (int p = 0; p < N; p++) set_req(p, 1'b1, AW'(30'h400 + p), 5'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
`ifdef L2_ARB_FIXED_PRIORITY_EN
      chk("all_rd_order", 64'(req_ack), 64'(order_fp[i]));
`else
      chk("all_rd_order", 64'(req_ack), 64'(order_rr[i]));
`endif
      cyc();
    end
    req_valid = '0;
    #1;
    cyc();

    // Port 1 write of 4 words; port 0 read queues up behind it.
    set_req(1, 1'b0, 30'h500, 5'd3);
    #1;
    chk("wr1_ack",   64'(req_ack),           64'(4'b0010));
    chk("wr1_rnw",   64'(rq_data.rnw),       64'(0));
    chk("wr1_burst", 64'(rq_data.burst_len), 64'(3));
    cyc();
    req_valid = '0;
    set_req(0, 1'b1, 30'h600, 5'd0);
    wr_valid = 4'b0011;
    wr_data[0*DW +: DW] = 32'hBAD0_BAD0;
    for (int k = 0; k < 4; k++) begin
      wr_data[1*DW +: DW] = 32'hD000_0000 + 32'(k);
      #1;
      chk("wr1_busy",   64'(busy),    64'(1));
      chk("wr1_wack",   64'(wr_ack),  64'(4'b0010));
      chk("wr1_wdata",  64'(wd_data), 64'(32'hD000_0000 + 32'(k)));
      chk("wr1_noreq",  64'(req_ack), 64'(0));
      cyc();
    end
    wr_valid = '0;
    #1;
    chk("wr1_done_busy", 64'(busy),    64'(0));
    chk("rd0_after_wr",  64'(req_ack), 64'(4'b0001));
    cyc();
    req_valid = '0;

    // Request FIFO full for three cycles with port 3 waiting.
    rq_full = 1'b1;
    set_req(3, 1'b1, 30'h700, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rqfull_noack", 64'(req_ack), 64'(0));
      chk("rqfull_nopush", 64'(rq_push), 64'(0));
      cyc();
    end
    rq_full = 1'b0;
    #1;
    chk("rqfull_release", 64'(req_ack), 64'(4'b1000));
    cyc();
    req_valid = '0;

    // Two-word write from port 2 against a toggling data-FIFO full.
    set_req(2, 1'b0, 30'h800, 5'd1);
    #1;
    chk("wr2_ack", 64'(req_ack), 64'(4'b0100));
    cyc();
    req_valid = '0;
    wr_valid = 4'b0100;
    wr_data[2*DW +: DW] = 32'hE000_0000;
    wd_full = 1'b1; #1;
    chk("wdfull_stall0", 64'(wd_push), 64'(0));
    chk("wdfull_busy0",  64'(busy),    64'(1));
    cyc();
    wd_full = 1'b0; #1;
    chk("wdfull_push0",  64'(wd_data), 64'(32'hE000_0000));
    cyc();
    wr_data[2*DW +: DW] = 32'hE000_0001;
    wd_full = 1'b1; #1;
    chk("wdfull_stall1", 64'(wd_push), 64'(0));
    chk("wdfull_busy1",  64'(busy),    64'(1));
    cyc();
    wd_full = 1'b0; #1;
    chk("wdfull_push1",  64'(wd_data), 64'(32'hE000_0001));
    chk("wdfull_wack1",  64'(wr_ack),  64'(4'b0100));
    cyc();
    wr_valid = '0;
    #1;
    chk("wdfull_idle", 64'(busy), 64'(0));
    cyc();

    // Reset lands during a 4-word write after one word.
    set_req(0, 1'b0, 30'h900, 5'd3);
    #1;
    chk("wr0_ack", 64'(req_ack), 64'(4'b0001));
    cyc();
    req_valid = '0;
    wr_valid = 4'b0001;
    wr_data[0*DW +: DW] = 32'hF000_0000;
    #1;
    chk("wr0_beat0", 64'(wd_push), 64'(1));
    cyc();
    wr_data[0*DW +: DW] = 32'hF000_0001;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy",    64'(busy),    64'(0));
    chk("midrst_wd_push", 64'(wd_push), 64'(0));
    chk("midrst_wr_ack",  64'(wr_ack),  64'(0));
    chk("midrst_rq_push", 64'(rq_push), 64'(0));
    cyc();
    rst = 1'b0;
    wr_valid = '0;
    set_req(1, 1'b1, 30'hA00, 5'd0);
    #1;
    chk("post_rst_rd", 64'(req_ack), 64'(4'b0010));
    chk("post_rst_id", 64'(rq_data.id), 64'(1));
    cyc();
    req_valid = '0;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
